fft_sample_loader: RTL

Streaming front end for the FFT sample memory. It accepts input samples on a valid/ready stream and writes each frame of `N_WORDS` samples into the sample memory through its single write port (`en`/`we`/`addr`/`data`), optionally in bit-reversed address order. After the last sample of a frame has been written, it pulses a start strobe to the FFT accelerator. It then holds off the stream until the accelerator reports completion.

---
 rtl/fft_sample_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fft_sample_loader.sv
// Streaming loader: writes N_WORDS-sample frames into the FFT sample memory (optionally
// bit-reversed), then starts the accelerator and stalls the stream until it reports done.
module fft_sample_loader #(
  parameter int unsigned N_WORDS   = 32,
  parameter int unsigned WORDWIDTH = 16,
  parameter int unsigned BITREV    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid_i,
  input  logic [WORDWIDTH-1:0]         s_data_i,
  input  logic                         s_last_i,
  output logic                         s_ready_o,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [$clog2(N_WORDS)-1:0]   mem_addr_o,
  output logic [WORDWIDTH-1:0]         mem_data_o,
  output logic                         start_o,
  input  logic                         done_i,
  output logic [$clog2(N_WORDS):0]     count_o,
  output logic                         frame_err_o
);

  localparam int unsigned AW = $clog2(N_WORDS);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LastIdx   = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] CountFull = CW'(N_WORDS);

  typedef enum logic [1:0] {StFill, StStart, StArm, StWait} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 mem_en_q, mem_en_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [WORDWIDTH-1:0] mem_data_q, mem_data_d;
  logic [AW-1:0]        beat_addr;
  logic                 accept;
  logic                 is_last_idx;

  assign accept      = s_valid_i && ready_q;
  assign is_last_idx = (count_q == LastIdx);

  always_comb begin
    beat_addr = count_q[AW-1:0];
    if (BITREV != 0) begin
      for (int b = 0; b < AW; b++) begin
        beat_addr[b] = count_q[AW-1-b];
      end
    end
  end

  // State register (plus the registered datapath it sequences).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFill;
      count_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          mem_en_d   = 1'b1;
          mem_addr_d = beat_addr;
          mem_data_d = s_data_i;
          if (is_last_idx) begin
            state_d = StStart;
            count_d = CountFull;
            if (!s_last_i) err_d = 1'b1;
          end else if (s_last_i) begin
            // Short frame: keep the written beat, discard the frame, no start.
            count_d = '0;
            err_d   = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StStart: state_d = StArm;
      StArm:   state_d = StWait;
      StWait: begin
        if (done_i) begin
          state_d = StFill;
          count_d = '0;
        end
      end
      default: state_d = StFill;
    endcase
    // Registered ready so it stays low during reset and rises one cycle later.
    ready_d = (state_d == StFill);
  end

  // Output logic.
  always_comb begin
    s_ready_o   = ready_q;
    mem_en_o    = mem_en_q;
    mem_we_o    = mem_en_q;
    mem_addr_o  = mem_addr_q;
    mem_data_o  = mem_data_q;
    start_o     = (state_q == StArm);
    count_o     = count_q;
    frame_err_o = err_q;
  end

endmodule
